// File: rtl/memory_pkg.sv
// Shared definitions for the Memory Matrix round controller.
package memory_pkg;

  localparam int BOARD_W           = 8;
  localparam int SHOW_CYCLES_DEF   = 50_000_000;
  localparam int SETTLE_CYCLES_DEF = 4;
  localparam int MAX_LIVES_DEF     = 3;

  // Controller states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_REGEN      = 3'd1,
    ST_SETTLE     = 3'd2,
    ST_SHOW       = 3'd3,
    ST_WAIT_GUESS = 3'd4,
    ST_CHECK      = 3'd5,
    ST_GAMEOVER   = 3'd6
  } state_e;

endpackage

// File: rtl/memory_round_ctrl_popcount8.sv
// Combinational ones count of an 8-bit vector (result 0..8).
module popcount8 (
  input  logic [7:0] bits_i,
  output logic [3:0] count_o
);

  // Sum the individual bits.
  always_comb begin
    count_o = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count_o = count_o + {3'b000, bits_i[i]};
    end
  end

endmodule

// File: rtl/memory_round_ctrl.sv
// Memory Matrix round sequencer: requests a board, shows it, collects the
// player's guess, scores it and tracks lives until the game ends.
module memory_round_ctrl
  import memory_pkg::*;
#(
  parameter int SHOW_CYCLES   = SHOW_CYCLES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int MAX_LIVES     = MAX_LIVES_DEF,
  parameter int SCORE_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BOARD_W-1:0] board,
  input  logic               go,
  input  logic [BOARD_W-1:0] guess,
  input  logic               submit,
  output logic               regen,
  output logic [BOARD_W-1:0] display,
  output logic               show_active,
  output logic               await_guess,
  output logic               last_ok,
  output logic [3:0]         mismatches,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic               game_over
);

  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] SHOW_LAST   = 32'(SHOW_CYCLES - 1);
  localparam logic [2:0]  LIVES_INIT  = 3'(MAX_LIVES);

  state_e             state_q,  state_d;
  logic [31:0]        settle_q, settle_d;
  logic [31:0]        show_q,   show_d;
  logic [BOARD_W-1:0] target_q, target_d;
  logic [BOARD_W-1:0] guess_q,  guess_d;
  logic [SCORE_W-1:0] score_q,  score_d;
  logic [2:0]         lives_q,  lives_d;
  logic               last_ok_q, last_ok_d;
  logic [3:0]         mism_q,   mism_d;
  logic               submit_q;
  logic               submit_edge_s;
  logic [3:0]         diff_cnt_s;

  assign submit_edge_s = submit & ~submit_q;

  popcount8 u_popcount (
    .bits_i  (guess_q ^ target_q),
    .count_o (diff_cnt_s)
  );

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      settle_q  <= 32'd0;
      show_q    <= 32'd0;
      target_q  <= '0;
      guess_q   <= '0;
      score_q   <= '0;
      lives_q   <= LIVES_INIT;
      last_ok_q <= 1'b0;
      mism_q    <= 4'd0;
      submit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      show_q    <= show_d;
      target_q  <= target_d;
      guess_q   <= guess_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      last_ok_q <= last_ok_d;
      mism_q    <= mism_d;
      submit_q  <= submit;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    show_d    = show_q;
    target_d  = target_q;
    guess_d   = guess_q;
    score_d   = score_q;
    lives_d   = lives_q;
    last_ok_d = last_ok_q;
    mism_d    = mism_q;
    case (state_q)
      ST_IDLE, ST_GAMEOVER: begin
        if (go) begin
          state_d = ST_REGEN;
          score_d = '0;
          lives_d = LIVES_INIT;
        end else begin
          state_d = state_q;
        end
      end
      ST_REGEN: begin
        state_d  = ST_SETTLE;
        settle_d = 32'd0;
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          // An all-zero board is unplayable; hold until the generator moves.
          if (board != '0) begin
            target_d = board;
            show_d   = 32'd0;
            state_d  = ST_SHOW;
          end else begin
            state_d  = ST_SETTLE;
          end
        end else begin
          settle_d = settle_q + 32'd1;
        end
      end
      ST_SHOW: begin
        if (show_q == SHOW_LAST) begin
          state_d = ST_WAIT_GUESS;
        end else begin
          show_d = show_q + 32'd1;
        end
      end
      ST_WAIT_GUESS: begin
        if (submit_edge_s) begin
          guess_d = guess;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_WAIT_GUESS;
        end
      end
      ST_CHECK: begin
        mism_d    = diff_cnt_s;
        last_ok_d = (diff_cnt_s == 4'd0);
        if (diff_cnt_s == 4'd0) begin
          if (!(&score_q)) begin
            score_d = score_q + {{(SCORE_W-1){1'b0}}, 1'b1};
          end else begin
            score_d = score_q;
          end
          state_d = ST_REGEN;
        end else begin
          lives_d = lives_q - 3'd1;
          if (lives_q == 3'd1) begin
            state_d = ST_GAMEOVER;
          end else begin
            state_d = ST_REGEN;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    regen       = 1'b0;
    display     = '0;
    show_active = 1'b0;
    await_guess = 1'b0;
    game_over   = 1'b0;
    case (state_q)
      ST_REGEN: begin
        regen = 1'b1;
      end
      ST_SHOW: begin
        display     = target_q;
        show_active = 1'b1;
      end
      ST_WAIT_GUESS: begin
        display     = guess;
        await_guess = 1'b1;
      end
      ST_GAMEOVER: begin
        display   = target_q;
        game_over = 1'b1;
      end
      default: begin
        display = '0;
      end
    endcase
  end

  assign last_ok    = last_ok_q;
  assign mismatches = mism_q;
  assign score      = score_q;
  assign lives      = lives_q;

endmodule

// File: tb/tb_memory_round_ctrl.sv
// Self-checking bench for memory_round_ctrl with a result scoreboard.
module tb_memory_round_ctrl;

  logic       clk = 1'b0;
  logic       reset, go, submit;
  logic [7:0] board, guess;
  logic       regen, show_active, await_guess, last_ok, game_over;
  logic [7:0] display, score;
  logic [3:0] mismatches;
  logic [2:0] lives;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] mm;
    logic       ok;
    logic [7:0] score;
    logic [2:0] lives;
    logic       gover;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_target;
  int         m_score;
  int         m_lives;

  memory_round_ctrl #(
    .SHOW_CYCLES  (8),
    .SETTLE_CYCLES(4),
    .MAX_LIVES    (3),
    .SCORE_W      (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .board      (board),
    .go         (go),
    .guess      (guess),
    .submit     (submit),
    .regen      (regen),
    .display    (display),
    .show_active(show_active),
    .await_guess(await_guess),
    .last_ok    (last_ok),
    .mismatches (mismatches),
    .score      (score),
    .lives      (lives),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [28:0] exp_v;
    reset = 1'b0; go = 1'b0; submit = 1'b0; board = 8'hA5; guess = 8'h00;
    tick(); tick();
    exp_v = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 3'd3, 1'b0};
    checks++;
    if ({regen, display, show_active, await_guess, last_ok, mismatches, score, lives, game_over} !== exp_v) begin
      failures++;
      $display("FAIL reset_values got=%h exp=%h",
               {regen, display, show_active, await_guess, last_ok, mismatches, score, lives, game_over}, exp_v);
    end
    m_score = 0; m_lives = 3; m_target = 8'h00;
    reset = 1'b1;
    tick();
    checks++;
    if (regen !== 1'b0) begin failures++; $display("FAIL idle_no_regen got=%b exp=0", regen); end
  endtask

  // Entry: the sampled cycle is the one in which regen is expected high.
  task automatic run_round(input logic [7:0] b, input bit zero_first, input bit hold_submit,
                           input int abort_at, output bit aborted);
    int n;
    aborted = 1'b0;
    checks++;
    if (regen !== 1'b1) begin failures++; $display("FAIL regen_pulse got=%b exp=1", regen); end
    board = zero_first ? 8'h00 : b;
    tick();
    checks++;
    if (regen !== 1'b0) begin failures++; $display("FAIL regen_width got=%b exp=0", regen); end
    if (zero_first) begin
      repeat (10) tick();
      checks++;
      if (show_active !== 1'b0) begin failures++; $display("FAIL zero_board_hold got=%b exp=0", show_active); end
      board = b;
      tick();
      checks++;
      if (show_active !== 1'b1) begin failures++; $display("FAIL zero_board_release got=%b exp=1", show_active); end
    end else begin
      n = 1;
      while (show_active !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      checks++;
      if (n != 5) begin failures++; $display("FAIL settle_latency got=%0d exp=5", n); end
    end
    m_target = b;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({show_active, display} !== {1'b1, b}) begin
        failures++;
        $display("FAIL show_cycle%0d got=%b/%h exp=1/%h", i, show_active, display, b);
      end
      if (i == abort_at) begin
        aborted = 1'b1;
        return;
      end
      if (hold_submit && i == 2) submit = 1'b1;
      tick();
    end
    checks++;
    if ({show_active, await_guess} !== 2'b01) begin
      failures++;
      $display("FAIL show_end got=%b%b exp=01", show_active, await_guess);
    end
    checks++;
    if (display !== guess) begin failures++; $display("FAIL guess_echo got=%h exp=%h", display, guess); end
  endtask

  task automatic do_submit(input logic [7:0] g);
    exp_t e;
    e.mm = 4'($countones(g ^ m_target));
    e.ok = (e.mm == 4'd0);
    if (e.ok) begin
      if (m_score < 255) m_score++;
    end else begin
      m_lives--;
    end
    e.score = 8'(m_score);
    e.lives = 3'(m_lives);
    e.gover = (m_lives == 0);
    sb.push_back(e);
    guess = g; submit = 1'b1;
    tick();
    checks++;
    if (await_guess !== 1'b0) begin failures++; $display("FAIL check_state got=%b exp=0", await_guess); end
    submit = 1'b0;
    tick();
    e = sb.pop_front();
    checks++;
    if ({mismatches, last_ok, score, lives, game_over} !== {e.mm, e.ok, e.score, e.lives, e.gover}) begin
      failures++;
      $display("FAIL result got=mm%0d ok%b sc%0d lv%0d go%b exp=mm%0d ok%b sc%0d lv%0d go%b",
               mismatches, last_ok, score, lives, game_over, e.mm, e.ok, e.score, e.lives, e.gover);
    end
    checks++;
    if (regen !== !e.gover) begin failures++; $display("FAIL result_regen got=%b exp=%b", regen, !e.gover); end
    if (e.gover) begin
      checks++;
      if (display !== m_target) begin failures++; $display("FAIL gameover_display got=%h exp=%h", display, m_target); end
    end
  endtask

  task automatic test_perfect();
    bit ab;
    board = 8'hA5; go = 1'b1;
    tick();
    go = 1'b0;
    run_round(8'hA5, 1'b0, 1'b0, -1, ab);
    do_submit(8'hA5);
  endtask

  task automatic test_wrong_guess();
    bit ab;
    run_round(8'hA5, 1'b0, 1'b0, -1, ab);
    do_submit(8'hA4);
    run_round(8'hA5, 1'b0, 1'b0, -1, ab);
    do_submit(8'h5A);
  endtask

  task automatic test_game_over();
    bit ab;
    run_round(8'hA5, 1'b0, 1'b0, -1, ab);
    do_submit(8'h00);
    repeat (3) tick();
    checks++;
    if ({game_over, display, score, lives, regen} !== {1'b1, 8'hA5, 8'd1, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL gameover_hold got=%b %h %0d %0d %b exp=1 a5 1 0 0", game_over, display, score, lives, regen);
    end
    go = 1'b1;
    tick();
    go = 1'b0;
    m_score = 0; m_lives = 3;
    checks++;
    if ({regen, game_over, score, lives} !== {1'b1, 1'b0, 8'd0, 3'd3}) begin
      failures++;
      $display("FAIL restart got=%b %b %0d %0d exp=1 0 0 3", regen, game_over, score, lives);
    end
  endtask

  task automatic test_zero_board_held_submit();
    bit ab;
    guess = 8'h01;
    run_round(8'h01, 1'b1, 1'b1, -1, ab);
    repeat (3) tick();
    checks++;
    if ({await_guess, score, lives} !== {1'b1, 8'd0, 3'd3}) begin
      failures++;
      $display("FAIL held_submit got=%b %0d %0d exp=1 0 3", await_guess, score, lives);
    end
    submit = 1'b0;
    tick();
    do_submit(8'h01);
  endtask

  task automatic test_reset_mid_show();
    bit ab;
    logic [28:0] exp_v;
    run_round(8'hA5, 1'b0, 1'b0, 3, ab);
    checks++;
    if (ab !== 1'b1) begin failures++; $display("FAIL abort_reached got=%b exp=1", ab); end
    reset = 1'b0;
    tick();
    exp_v = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 3'd3, 1'b0};
    checks++;
    if ({regen, display, show_active, await_guess, last_ok, mismatches, score, lives, game_over} !== exp_v) begin
      failures++;
      $display("FAIL mid_reset got=%h exp=%h",
               {regen, display, show_active, await_guess, last_ok, mismatches, score, lives, game_over}, exp_v);
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({regen, show_active, game_over} !== 3'b000) begin
        failures++;
        $display("FAIL post_reset_idle%0d got=%b exp=000", i, {regen, show_active, game_over});
      end
    end
  endtask

  initial begin
    test_reset();
    test_perfect();
    test_wrong_guess();
    test_game_over();
    test_zero_board_held_submit();
    test_reset_mid_show();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
